// File: rtl/gpio_in_ip.sv
// gpio_in_ip: input GPIO block; 2-flop synchronizer, per-pin edge capture, 4-register bus map, level irq.
// Latency: pin change before edge N -> EDGE set at N+2 (N+2+DB_CYCLES with DEBOUNCE_EN), irq at N+3.
// Optional macro DEBOUNCE_EN adds a per-pin stability filter of DB_CYCLES clocks ahead of edge detection.
module gpio_in_ip #(
  parameter int WIDTH     = 32,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [1:0]       addr,
  input  logic             write_en,
  input  logic             read_en,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_POL  = 2'd3;

  // Reject configurations the filter counter cannot represent.
  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("gpio_in_ip: DB_CYCLES must be >= 2");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_flags;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] pol;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] wbits;
  logic [31:0]      rd_val;
  logic             wr_acc;
  logic             rd_acc;

  assign wr_acc = sel & write_en;
  assign rd_acc = sel & read_en;
  assign wbits  = wdata[WIDTH-1:0];

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt [WIDTH];

  // Per-pin stability filter: accept a new level only after it persists DB_CYCLES clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign filt = sync2;
`endif

  // Edge polarity select: POL=0 detects rising, POL=1 detects falling.
  assign evt = (filt & ~prev & ~pol) | (~filt & prev & pol);

  // Edge history; never flushed on POL writes so a polarity change alone cannot fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= filt;
  end

  // Sticky edge flags with write-1-to-clear; a same-cycle event overrides the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_flags <= '0;
    end else if (wr_acc && addr == ADDR_EDGE) begin
      edge_flags <= (edge_flags & ~wbits) | evt;
    end else begin
      edge_flags <= edge_flags | evt;
    end
  end

  // MASK and POL configuration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
      pol  <= '0;
    end else if (wr_acc) begin
      if (addr == ADDR_MASK) mask <= wbits;
      if (addr == ADDR_POL)  pol  <= wbits;
    end
  end

  // Read mux over pre-write register values, zero-extended to the bus width.
  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_DATA: rd_val[WIDTH-1:0] = filt;
      ADDR_EDGE: rd_val[WIDTH-1:0] = edge_flags;
      ADDR_MASK: rd_val[WIDTH-1:0] = mask;
      ADDR_POL:  rd_val[WIDTH-1:0] = pol;
      default:   rd_val = '0;
    endcase
  end

  // Registered read data; holds when no read is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdata <= '0;
    else if (rd_acc) rdata <= rd_val;
  end

  // Registered level interrupt from any enabled pending edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(edge_flags & mask);
  end

endmodule
